// File: rtl/hs_pkg.sv
// Shared constants and helpers for the valid/ready pipeline chain.
package hs_pkg;

  localparam int MAX_STAGES = 8;
  localparam int MAX_DATA_W = 512;

  // Ceiling log2 for sizing counters; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hs_pipe_slice.sv
// One valid/ready register slice. SKID=0 is a bubble-collapsing register
// whose ready looks through to the downstream ready; SKID=1 adds a second
// entry so upstream ready comes straight from a flop.
module hs_pipe_slice #(
  parameter int DATA_W = 64,
  parameter int SKID   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;

  // Flush hides the held word so nothing moves during the clearing cycle.
  assign dn_valid = main_valid && !flush;
  assign dn_data  = main_data;

  if (SKID == 0) begin : g_pass
    // Free now, or frees on this edge because the word ahead leaves.
    assign up_ready = (!main_valid || dn_ready) && !flush;

    // Main register: take whatever upstream offers when there is room.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_valid <= 1'b0;
        main_data  <= '0;
      end else if (flush) begin
        main_valid <= 1'b0;
      end else if (up_ready) begin
        main_valid <= up_valid;
        if (up_valid) main_data <= up_data;
      end
    end
  end else begin : g_skid
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              advance;

    // Ready depends only on the skid flop, never on dn_ready.
    assign up_ready = !skid_valid && !flush;
    assign accept   = up_valid && up_ready;
    assign advance  = !main_valid || dn_ready;

    // Main/skid pair: the skid entry catches the word that arrives while
    // the main entry is stalled, and drains into main first once it moves.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_valid <= 1'b0;
        main_data  <= '0;
        skid_valid <= 1'b0;
        skid_data  <= '0;
      end else if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (advance) begin
        if (skid_valid) begin
          main_data  <= skid_data;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= accept;
          if (accept) main_data <= up_data;
        end
      end else if (accept) begin
        skid_data  <= up_data;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hs_pipe_chain.sv
// Chain of STAGES handshake slices with an occupancy counter and a
// synchronous flush, used to cut long valid/data/ready paths.
module hs_pipe_chain
  import hs_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int STAGES = 2,
  parameter int SKID   = 0,
  localparam int CNT_W = clog2(2 * STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              rx_hs_valid,
  output logic              rx_hs_ready,
  input  logic [DATA_W-1:0] rx_hs_data,
  output logic              tx_hs_valid,
  input  logic              tx_hs_ready,
  output logic [DATA_W-1:0] tx_hs_data,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int MAX_OCC = (SKID != 0) ? 2 * STAGES : STAGES;

  if (DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $error("hs_pipe_chain: DATA_W out of range");
  end
  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("hs_pipe_chain: STAGES out of range");
  end

  logic              link_valid [STAGES+1];
  logic              link_ready [STAGES+1];
  logic [DATA_W-1:0] link_data  [STAGES+1];
  logic              rx_fire;
  logic              tx_fire;

  assign link_valid[0]      = rx_hs_valid;
  assign link_data[0]       = rx_hs_data;
  assign link_ready[STAGES] = tx_hs_ready;

  // Slices are already empty while rst is high; ready is held low anyway.
  assign rx_hs_ready = link_ready[0] && !rst;
  assign tx_hs_valid = link_valid[STAGES];
  assign tx_hs_data  = link_data[STAGES];

  assign rx_fire = rx_hs_valid && rx_hs_ready;
  assign tx_fire = tx_hs_valid && tx_hs_ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_slice
    hs_pipe_slice #(
      .DATA_W (DATA_W),
      .SKID   (SKID)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (link_valid[gi]),
      .up_ready (link_ready[gi]),
      .up_data  (link_data[gi]),
      .dn_valid (link_valid[gi+1]),
      .dn_ready (link_ready[gi+1]),
      .dn_data  (link_data[gi+1])
    );
  end

  // Word count tracked from the two boundary handshakes; clamped so it can
  // never wrap even if the ends were misused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (rx_fire && !tx_fire && occupancy != CNT_W'(MAX_OCC)) begin
      occupancy <= occupancy + CNT_W'(1);
    end else if (tx_fire && !rx_fire && occupancy != '0) begin
      occupancy <= occupancy - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hs_pipe_chain.sv
// Bench for hs_pipe_chain: four configurations side by side, each with a
// queue scoreboard, plus directed sequences for flush, fill/drain, ready
// independence in skid mode and asynchronous reset.
module tb_hs_pipe_chain;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        r;
    logic        f;
    logic        e_rdy;
    logic        e_val;
    logic [63:0] e_data;
    logic        chk_d;
    int          e_occ;
  } vec_t;

  localparam int STG [4] = '{2, 3, 1, 1};
  localparam int SKD [4] = '{0, 1, 0, 1};

  logic        clk;
  logic        rst;
  logic        rxv [4];
  logic [63:0] rxd [4];
  logic        txr [4];
  logic        fl  [4];
  logic        rxr [4];
  logic        txv [4];
  logic [63:0] txd [4];
  int          occv [4];

  logic [63:0] txd0, txd1;
  logic [7:0]  txd2, txd3;
  logic [2:0]  occ0, occ1;
  logic [1:0]  occ2, occ3;

  int n_checks = 0;
  int n_err    = 0;

  vec_t tbl [8];

  assign txd[0] = txd0;
  assign txd[1] = txd1;
  assign txd[2] = {56'b0, txd2};
  assign txd[3] = {56'b0, txd3};
  assign occv[0] = int'(occ0);
  assign occv[1] = int'(occ1);
  assign occv[2] = int'(occ2);
  assign occv[3] = int'(occ3);

  hs_pipe_chain #(.DATA_W(64), .STAGES(2), .SKID(0)) u0 (
    .clk(clk), .rst(rst), .flush(fl[0]),
    .rx_hs_valid(rxv[0]), .rx_hs_ready(rxr[0]), .rx_hs_data(rxd[0]),
    .tx_hs_valid(txv[0]), .tx_hs_ready(txr[0]), .tx_hs_data(txd0),
    .occupancy(occ0));

  hs_pipe_chain #(.DATA_W(64), .STAGES(3), .SKID(1)) u1 (
    .clk(clk), .rst(rst), .flush(fl[1]),
    .rx_hs_valid(rxv[1]), .rx_hs_ready(rxr[1]), .rx_hs_data(rxd[1]),
    .tx_hs_valid(txv[1]), .tx_hs_ready(txr[1]), .tx_hs_data(txd1),
    .occupancy(occ1));

  hs_pipe_chain #(.DATA_W(8), .STAGES(1), .SKID(0)) u2 (
    .clk(clk), .rst(rst), .flush(fl[2]),
    .rx_hs_valid(rxv[2]), .rx_hs_ready(rxr[2]), .rx_hs_data(rxd[2][7:0]),
    .tx_hs_valid(txv[2]), .tx_hs_ready(txr[2]), .tx_hs_data(txd2),
    .occupancy(occ2));

  hs_pipe_chain #(.DATA_W(8), .STAGES(1), .SKID(1)) u3 (
    .clk(clk), .rst(rst), .flush(fl[3]),
    .rx_hs_valid(rxv[3]), .rx_hs_ready(rxr[3]), .rx_hs_data(rxd[3][7:0]),
    .tx_hs_valid(txv[3]), .tx_hs_ready(txr[3]), .tx_hs_data(txd3),
    .occupancy(occ3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [63:0] d, input logic r,
                              input logic f, input logic e_rdy, input logic e_val,
                              input logic [63:0] e_data, input logic chk_d, input int e_occ);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.f = f;
    t.e_rdy = e_rdy; t.e_val = e_val; t.e_data = e_data; t.chk_d = chk_d; t.e_occ = e_occ;
    return t;
  endfunction

  // Scoreboard per DUT: push on observed rx handshake, pop and compare on tx.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mon
    localparam int CAP = (SKD[gi] != 0) ? 2 * STG[gi] : STG[gi];
    logic [63:0] sbq [$];

    initial begin
      logic        hold;
      logic [63:0] hold_data;
      logic        rx_f;
      logic        tx_f;
      int          depth;
      hold      = 1'b0;
      hold_data = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          sbq.delete();
          hold = 1'b0;
        end else begin
          depth = sbq.size();
          check($sformatf("d%0d_occ", gi), 64'(occv[gi]), 64'(depth));
          check($sformatf("d%0d_occ_cap", gi), 64'(occv[gi] > CAP), 64'(0));
          if (SKD[gi] == 0)
            check($sformatf("d%0d_ready_model", gi), 64'(rxr[gi]),
                  64'(!fl[gi] && (depth < STG[gi] || txr[gi])));
          if (fl[gi]) begin
            check($sformatf("d%0d_flush_rx_ready", gi), 64'(rxr[gi]), 64'(0));
            check($sformatf("d%0d_flush_tx_valid", gi), 64'(txv[gi]), 64'(0));
          end
          if (hold && !fl[gi]) begin
            check($sformatf("d%0d_valid_held", gi), 64'(txv[gi]), 64'(1));
            check($sformatf("d%0d_data_held", gi), txd[gi], hold_data);
          end
          rx_f = rxv[gi] && rxr[gi];
          tx_f = txv[gi] && txr[gi];
          if (tx_f) begin
            $display("d%0d tx data=%0h", gi, txd[gi]);
            if (sbq.size() == 0) begin
              n_checks++;
              n_err++;
              $display("FAIL d%0d_underflow: got %0h, expected no word", gi, txd[gi]);
            end else begin
              check($sformatf("d%0d_order", gi), txd[gi], sbq.pop_front());
            end
          end
          if (rx_f) sbq.push_back(rxd[gi]);
          if (fl[gi]) sbq.delete();
          hold      = txv[gi] && !txr[gi];
          hold_data = txd[gi];
        end
        @(posedge clk);
        if (rst) begin
          sbq.delete();
          hold = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    int          acc;
    int          seq;
    logic        pend;
    logic        acc_now;
    logic        r0;
    logic        pend2, pend3;
    logic [7:0]  seq2, seq3;

    tbl[0] = mk(1'b1, 64'hA, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 0);
    tbl[1] = mk(1'b1, 64'hB, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1);
    tbl[2] = mk(1'b1, 64'hC, 1'b0, 1'b0, 1'b0, 1'b1, 64'hA, 1'b1, 2);
    tbl[3] = mk(1'b1, 64'hC, 1'b0, 1'b1, 1'b0, 1'b0, 64'hA, 1'b1, 2);
    tbl[4] = mk(1'b1, 64'hC, 1'b0, 1'b0, 1'b1, 1'b0, 64'hA, 1'b1, 0);
    tbl[5] = mk(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 64'hA, 1'b1, 1);
    tbl[6] = mk(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 64'hC, 1'b1, 1);
    tbl[7] = mk(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 64'hC, 1'b1, 0);

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rxv[i] = 1'b0; rxd[i] = '0; txr[i] = 1'b0; fl[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_rx_ready_d%0d", i), 64'(rxr[i]), 64'(0));
      check($sformatf("reset_tx_valid_d%0d", i), 64'(txv[i]), 64'(0));
      check($sformatf("reset_tx_data_d%0d", i), txd[i], 64'(0));
      check($sformatf("reset_occ_d%0d", i), 64'(occv[i]), 64'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Flush sequence on STAGES=2, SKID=0, driven from the table.
    for (int i = 0; i < 8; i++) begin
      rxv[0] = tbl[i].v; rxd[0] = tbl[i].d; txr[0] = tbl[i].r; fl[0] = tbl[i].f;
      @(negedge clk);
      $display("row%0d rdy=%0d val=%0d data=%0h occ=%0d", i, rxr[0], txv[0], txd[0], occv[0]);
      check($sformatf("row%0d_rx_ready", i), 64'(rxr[0]), 64'(tbl[i].e_rdy));
      check($sformatf("row%0d_tx_valid", i), 64'(txv[0]), 64'(tbl[i].e_val));
      if (tbl[i].chk_d) check($sformatf("row%0d_tx_data", i), txd[0], tbl[i].e_data);
      check($sformatf("row%0d_occ", i), 64'(occv[0]), 64'(tbl[i].e_occ));
      @(posedge clk);
      #1;
    end
    fl[0] = 1'b0;

    // Back-to-back stream 0x1..0x10 with downstream always ready.
    for (int r = 0; r < 19; r++) begin
      rxv[0] = (r < 16);
      rxd[0] = 64'(r + 1);
      txr[0] = 1'b1;
      @(negedge clk);
      if (r < 16) check($sformatf("stream_rx_ready_%0d", r), 64'(rxr[0]), 64'(1));
      if (r >= 2 && r <= 17) begin
        check($sformatf("stream_tx_valid_%0d", r), 64'(txv[0]), 64'(1));
        check($sformatf("stream_tx_data_%0d", r), txd[0], 64'(r - 1));
      end
      if (r == 18) check("stream_tx_empty", 64'(txv[0]), 64'(0));
      if (r >= 2 && r <= 16) check($sformatf("stream_occ_%0d", r), 64'(occv[0]), 64'(2));
      @(posedge clk);
      #1;
    end
    rxv[0] = 1'b0;

    // Fill STAGES=3 skid chain with downstream stalled, then drain.
    acc = 0;
    txr[1] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rxv[1] = 1'b1;
      rxd[1] = 64'h100 + 64'(acc);
      @(negedge clk);
      if (!rxr[1]) break;
      acc++;
      @(posedge clk);
      #1;
    end
    rxv[1] = 1'b0;
    check("fill_accept_count", 64'(acc), 64'(6));
    check("fill_occ", 64'(occv[1]), 64'(6));
    @(posedge clk);
    #1;
    txr[1] = 1'b1;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j < 6) begin
        check($sformatf("drain_valid_%0d", j), 64'(txv[1]), 64'(1));
        check($sformatf("drain_data_%0d", j), txd[1], 64'h100 + 64'(j));
        check($sformatf("drain_occ_%0d", j), 64'(occv[1]), 64'(6 - j));
      end else begin
        check("drain_empty", 64'(txv[1]), 64'(0));
      end
      @(posedge clk);
      #1;
    end

    // Skid mode: toggling downstream ready, random upstream, ready probe.
    pend = 1'b0;
    seq  = 32'h3000;
    for (int k = 0; k < 200; k++) begin
      txr[1] = (k % 2 == 0);
      rxv[1] = pend ? 1'b1 : 1'($urandom_range(0, 1));
      rxd[1] = 64'(seq);
      @(negedge clk);
      acc_now = rxv[1] && rxr[1];
      #2;
      r0 = rxr[1];
      txr[1] = !txr[1];
      #1;
      check("skid_ready_indep", 64'(rxr[1]), 64'(r0));
      txr[1] = !txr[1];
      if (acc_now) seq++;
      pend = rxv[1] && !acc_now;
      @(posedge clk);
      #1;
    end
    rxv[1] = 1'b0;
    txr[1] = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("toggle_end_occ", 64'(occv[1]), 64'(0));
    check("toggle_end_valid", 64'(txv[1]), 64'(0));

    // Asynchronous reset with four words in flight.
    @(posedge clk);
    #1;
    txr[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rxv[1] = 1'b1;
      rxd[1] = 64'h200 + 64'(k);
      @(posedge clk);
      #1;
    end
    rxv[1] = 1'b0;
    @(negedge clk);
    check("pre_reset_occ", 64'(occv[1]), 64'(4));
    check("pre_reset_valid", 64'(txv[1]), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tx_valid", 64'(txv[1]), 64'(0));
    check("async_rst_tx_data", txd[1], 64'(0));
    check("async_rst_occ", 64'(occv[1]), 64'(0));
    check("async_rst_rx_ready", 64'(rxr[1]), 64'(0));
    @(posedge clk);
    #1;
    check("rst_hold_occ", 64'(occv[1]), 64'(0));
    check("rst_hold_rx_ready", 64'(rxr[1]), 64'(0));
    rxv[1] = 1'b1;
    rxd[1] = 64'h4444;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx_valid", 64'(txv[1]), 64'(0));
    @(posedge clk);
    #1;
    rxv[1] = 1'b0;
    check("first_accept_occ", 64'(occv[1]), 64'(1));
    txr[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // DATA_W=8, STAGES=1 corner in both modes under random handshakes.
    pend2 = 1'b0; pend3 = 1'b0; seq2 = 8'h00; seq3 = 8'h80;
    for (int k = 0; k < 1000; k++) begin
      txr[2] = 1'($urandom_range(0, 1));
      txr[3] = 1'($urandom_range(0, 1));
      rxv[2] = pend2 ? 1'b1 : 1'($urandom_range(0, 1));
      rxv[3] = pend3 ? 1'b1 : 1'($urandom_range(0, 1));
      rxd[2] = {56'b0, seq2};
      rxd[3] = {56'b0, seq3};
      @(negedge clk);
      if (rxv[2] && rxr[2]) begin seq2++; pend2 = 1'b0; end else pend2 = rxv[2];
      if (rxv[3] && rxr[3]) begin seq3++; pend3 = 1'b0; end else pend3 = rxv[3];
      @(posedge clk);
      #1;
    end
    rxv[2] = 1'b0; rxv[3] = 1'b0;
    txr[2] = 1'b1; txr[3] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("corner_end_occ_skid0", 64'(occv[2]), 64'(0));
    check("corner_end_occ_skid1", 64'(occv[3]), 64'(0));
    check("corner_end_valid_skid0", 64'(txv[2]), 64'(0));
    check("corner_end_valid_skid1", 64'(txv[3]), 64'(0));

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
